// File: rtl/note_sequencer.sv
// Queued note player: buffers {note, duration} entries and plays them one at a time.
// Each note is followed by a silent gap. Durations are counted in prescaled ticks.
module note_sequencer #(
  parameter int TICK_DIV  = 120000,
  parameter int GAP_TICKS = 2,
  parameter int DEPTH     = 8
) (
  input  logic       clk12MHz,
  input  logic       rstn,
  input  logic       flush,
  input  logic       wr_valid,
  input  logic [7:0] wr_note,
  input  logic [7:0] wr_dur,
  output logic       wr_ready,
  output logic [7:0] midi_note,
  output logic       note_start,
  output logic       busy,
  output logic [4:0] level
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_LAST  = 8'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [4:0]  DEPTH_L   = 5'(DEPTH);
  localparam logic        HAS_GAP   = (GAP_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [7:0]     midi_note_reg, midi_note_next;
  logic           note_start_reg, note_start_next;
  logic [4:0]     level_reg, level_next;
  logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [16:0]    cyc_cnt_reg, cyc_cnt_next;
  logic [7:0]     tick_cnt_reg, tick_cnt_next;
  logic [7:0]     dur_reg, dur_next;

  logic [7:0]     note_mem [DEPTH];
  logic [7:0]     dur_mem  [DEPTH];

  logic [7:0]     head_note, head_dur;
  logic           push, pop, pop_slot, tick_end, note_end, gap_end;

  // Head is read combinationally so an entry written into an idle, empty queue
  // can start sounding on the very next edge.
  assign head_note = note_mem[rd_ptr_reg];
  assign head_dur  = dur_mem[rd_ptr_reg];

  assign wr_ready = (level_reg != DEPTH_L);
  assign push     = wr_valid && wr_ready && !flush;

  assign tick_end = (cyc_cnt_reg == TICK_LAST);
  assign note_end = (state_reg == NOTE) && tick_end && (tick_cnt_reg == dur_reg - 8'd1);
  assign gap_end  = (state_reg == GAP) && tick_end && (tick_cnt_reg == GAP_LAST);
  // With no gap configured the end of a note is itself the decision point.
  assign pop_slot = (state_reg == IDLE) || gap_end || (note_end && !HAS_GAP);
  assign pop      = pop_slot && (level_reg != 5'd0) && !flush;

  always_ff @(posedge clk12MHz) begin
    if (push) begin
      note_mem[wr_ptr_reg] <= wr_note;
      dur_mem[wr_ptr_reg]  <= wr_dur;
    end
  end

  // State register
  always_ff @(posedge clk12MHz or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      midi_note_reg  <= 8'd0;
      note_start_reg <= 1'b0;
      level_reg      <= 5'd0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cyc_cnt_reg    <= 17'd0;
      tick_cnt_reg   <= 8'd0;
      dur_reg        <= 8'd0;
    end else begin
      state_reg      <= state_next;
      midi_note_reg  <= midi_note_next;
      note_start_reg <= note_start_next;
      level_reg      <= level_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      tick_cnt_reg   <= tick_cnt_next;
      dur_reg        <= dur_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else if (pop) begin
      state_next = (head_dur != 8'd0) ? NOTE : IDLE;
    end else if (pop_slot) begin
      state_next = IDLE;
    end else if (note_end) begin
      state_next = GAP;
    end
  end

  // Output logic
  always_comb begin
    midi_note_next  = midi_note_reg;
    note_start_next = 1'b0;
    if (flush) begin
      midi_note_next = 8'd0;
    end else if (pop) begin
      midi_note_next  = (head_dur != 8'd0) ? head_note : 8'd0;
      note_start_next = (head_dur != 8'd0);
    end else if (note_end) begin
      midi_note_next = 8'd0;
    end
  end

  // Queue bookkeeping and tick counters
  always_comb begin
    wr_ptr_next   = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next   = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    level_next    = level_reg;
    dur_next      = pop ? head_dur : dur_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    tick_cnt_next = tick_cnt_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 5'd1;
      2'b01:   level_next = level_reg - 5'd1;
      default: level_next = level_reg;
    endcase
    // Counters restart on every state entry so each phase lasts exact whole ticks.
    if (flush || pop_slot || note_end || state_reg == IDLE) begin
      cyc_cnt_next  = 17'd0;
      tick_cnt_next = 8'd0;
    end else if (tick_end) begin
      cyc_cnt_next  = 17'd0;
      tick_cnt_next = tick_cnt_reg + 8'd1;
    end else begin
      cyc_cnt_next  = cyc_cnt_reg + 17'd1;
    end
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = 5'd0;
      dur_next    = 8'd0;
    end
  end

  assign midi_note  = midi_note_reg;
  assign note_start = note_start_reg;
  assign level      = level_reg;
  assign busy       = (state_reg != IDLE) || (level_reg != 5'd0);

endmodule
